// File: rtl/des_f_round_sbox_ctrl.sv
// DES round function f(R,K) sequencer: expands R, mixes in K, drives eight registered S-boxes, permutes the result.
// Optional macro DES_F_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES with a sticky timeout_err.
module des_f_round_sbox_ctrl
`ifdef DES_F_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 4)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey_in,
  output logic [47:0] sbox_in,
  output logic [7:0]  sbox_sel,
  input  logic [31:0] sbox_out,
  input  logic [7:0]  sbox_finish,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_out,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        capture;
  logic        all_done;
  logic [47:0] sbox_in_p0;
  logic [31:0] f_out_p1;

  // Vector bit 31 is DES bit 1, so DES bit n lives at index 32-n.
  function automatic logic [47:0] e_expand(input logic [31:0] r);
    return {r[0],  r[31], r[30], r[29], r[28], r[27],
            r[28], r[27], r[26], r[25], r[24], r[23],
            r[24], r[23], r[22], r[21], r[20], r[19],
            r[20], r[19], r[18], r[17], r[16], r[15],
            r[16], r[15], r[14], r[13], r[12], r[11],
            r[12], r[11], r[10], r[9],  r[8],  r[7],
            r[8],  r[7],  r[6],  r[5],  r[4],  r[3],
            r[4],  r[3],  r[2],  r[1],  r[0],  r[31]};
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] s);
    return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
            s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
            s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
            s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
  endfunction

  assign all_done = (sbox_finish == 8'hFF);

`ifdef DES_F_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             expire;
  logic             timeout_err_q;

  assign expire = (state_q == ST_WAIT) && !all_done && (wait_cnt == CNT_LAST);

  // Counter restarts on every WAIT entry; it never runs past CNT_LAST because expiry leaves WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_q != ST_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_q <= 1'b0;
    end else if (expire) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (all_done) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
`ifdef DES_F_TIMEOUT_EN
        else if (expire) begin
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sbox_sel  = {8{state_q == ST_ISSUE}};

  // Stage p0: E(R) xor K, held for the S-boxes from ISSUE through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbox_in_p0 <= '0;
    end else if (accept) begin
      sbox_in_p0 <= e_expand(r_in) ^ subkey_in;
    end
  end

  // Stage p1: permuted substitution result, held through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_out_p1 <= '0;
    end else if (capture) begin
      f_out_p1 <= p_perm(sbox_out);
    end
`ifdef DES_F_TIMEOUT_EN
    else if (expire) begin
      f_out_p1 <= '0;
    end
`endif
  end

  assign sbox_in = sbox_in_p0;
  assign f_out   = f_out_p1;

endmodule

// File: tb/tb_des_f_round_sbox_ctrl.sv
// Testbench for des_f_round_sbox_ctrl with a behavioural S-box model and a table-driven DES f reference.
module tb_des_f_round_sbox_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] r_in;
  logic [47:0] subkey_in;
  logic [47:0] sbox_in;
  logic [7:0]  sbox_sel;
  logic [31:0] sbox_out;
  logic [7:0]  sbox_finish;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f_out;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  // S-box model mode: 0 real tables, 1 finish stuck at FE, 2 fixed stub value, 3 manual finish
  int          mode = 0;
  logic [31:0] stub_val = '0;
  logic [7:0]  man_fin = '0;
  logic [31:0] sb_out_q = '0;
  logic [7:0]  sb_fin_q = '0;

  always #5 clk = ~clk;

  des_f_round_sbox_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .r_in        (r_in),
    .subkey_in   (subkey_in),
    .sbox_in     (sbox_in),
    .sbox_sel    (sbox_sel),
    .sbox_out    (sbox_out),
    .sbox_finish (sbox_finish),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .f_out       (f_out),
    .timeout_err (timeout_err)
  );

  int P_TAB [0:31] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                       2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  byte unsigned SBT [0:7][0:63] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  // E: group g takes the four R bits 4g+1..4g+4 plus one wrapped neighbour on each side.
  function automatic logic [47:0] e_ref(input logic [31:0] r);
    logic [47:0] e;
    int src;
    e = '0;
    for (int g = 0; g < 8; g++) begin
      for (int j = 0; j < 6; j++) begin
        src = ((4 * g + j + 31) % 32) + 1;
        e[47 - (6 * g + j)] = r[32 - src];
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] sbox_ref(input logic [47:0] x);
    logic [31:0] s;
    logic [5:0]  grp;
    int          idx;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      grp = x[47 - 6 * i -: 6];
      idx = {grp[5], grp[0]} * 16 + grp[4:1];
      s[31 - 4 * i -: 4] = SBT[i][idx][3:0];
    end
    return s;
  endfunction

  function automatic logic [31:0] p_ref(input logic [31:0] s);
    logic [31:0] f;
    f = '0;
    for (int k = 0; k < 32; k++) begin
      f[31 - k] = s[32 - P_TAB[k]];
    end
    return f;
  endfunction

  function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
    return p_ref(sbox_ref(e_ref(r) ^ k));
  endfunction

  // Behavioural registered S-boxes: result and finish flags appear the cycle after the select pulse.
  always @(posedge clk) begin
    if (sbox_sel != 8'h00) begin
      sb_out_q <= (mode == 0) ? sbox_ref(sbox_in) : stub_val;
    end
    sb_fin_q <= (mode == 1) ? 8'hFE : sbox_sel;
  end

  assign sbox_out    = sb_out_q;
  assign sbox_finish = (mode == 3) ? man_fin : sb_fin_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [31:0] r, input logic [47:0] k,
                     input logic [47:0] exp_sin, input logic [31:0] exp_f, input int hold);
    check("rdy_idle", in_ready, 1);
    in_valid = 1'b1;
    r_in = r;
    subkey_in = k;
    tick();
    in_valid = 1'b0;
    check("sel_issue", sbox_sel, 8'hFF);
    check("sbox_in", sbox_in, exp_sin);
    check("rdy_busy", in_ready, 0);
    check("vld_issue", out_valid, 0);
    tick();
    check("sel_wait", sbox_sel, 8'h00);
    check("sbox_in_hold", sbox_in, exp_sin);
    check("vld_wait", out_valid, 0);
    tick();
    check("vld_done", out_valid, 1);
    check("f_out", f_out, exp_f);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      r_in = ~r;
      tick();
      check("vld_hold", out_valid, 1);
      check("f_hold", f_out, exp_f);
      check("rdy_hold", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("vld_after", out_valid, 0);
    check("rdy_after", in_ready, 1);
    check("f_keep", f_out, exp_f);
    tick();
    check("vld_single", out_valid, 0);
  endtask

  logic [31:0] rq [0:2];
  logic [47:0] kq [0:2];
  logic [31:0] rr;
  logic [47:0] kk;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    r_in = '0;
    subkey_in = '0;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sbox_sel", sbox_sel, 8'h00);
    check("rst_sbox_in", sbox_in, 48'h0);
    check("rst_f_out", f_out, 32'h0);
    check("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;
    tick();

    // Known DES round-1 vector, then the same request with a stalled consumer
    txn(32'hF0AAF0AA, 48'h1B02EFFC7072, 48'h6117BA866527, 32'h234AA9BB, 0);
    txn(32'hF0AAF0AA, 48'h1B02EFFC7072, 48'h6117BA866527, 32'h234AA9BB, 5);

    // Single S bit routed through P
    mode = 2;
    stub_val = 32'h80000000;
    txn(32'h0, 48'h0, 48'h0, 32'h00800000, 0);
    stub_val = $urandom;
    rr = $urandom;
    kk = {16'($urandom), $urandom};
    txn(rr, kk, e_ref(rr) ^ kk, p_ref(stub_val), 1);
    mode = 0;

    // Random single requests against the full reference
    for (int i = 0; i < 2; i++) begin
      rr = $urandom;
      kk = {16'($urandom), $urandom};
      txn(rr, kk, e_ref(rr) ^ kk, f_ref(rr, kk), i);
    end

    // Back-to-back with out_ready tied high
    for (int i = 0; i < 3; i++) begin
      rq[i] = $urandom;
      kq[i] = {16'($urandom), $urandom};
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      r_in = rq[c / 4];
      subkey_in = kq[c / 4];
      in_valid = (c < 9);
      check("b2b_rdy", in_ready, (c % 4 == 0));
      check("b2b_vld", out_valid, (c % 4 == 3));
      if (c % 4 == 3) check("b2b_f", f_out, f_ref(rq[c / 4], kq[c / 4]));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_end_rdy", in_ready, 1);

    // Asynchronous reset while waiting for the S-boxes
    mode = 3;
    man_fin = 8'h00;
    in_valid = 1'b1;
    r_in = $urandom;
    subkey_in = {16'($urandom), $urandom};
    tick();
    in_valid = 1'b0;
    tick();
    check("mid_wait_vld", out_valid, 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_sbox_sel", sbox_sel, 8'h00);
    check("arst_sbox_in", sbox_in, 48'h0);
    check("arst_f_out", f_out, 32'h0);
    tick();
    rst_n = 1'b1;
    man_fin = 8'hFF;
    tick();
    man_fin = 8'h00;
    check("late_fin_vld", out_valid, 0);
    check("late_fin_rdy", in_ready, 1);
    tick();
    check("late_fin_vld2", out_valid, 0);

    // Partial finish pattern never completes the wait
    mode = 1;
    in_valid = 1'b1;
    r_in = $urandom;
    subkey_in = {16'($urandom), $urandom};
    tick();
    in_valid = 1'b0;
    tick();
`ifdef DES_F_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_pending_vld", out_valid, 0);
      check("to_pending_err", timeout_err, 0);
    end
    tick();
    check("to_vld", out_valid, 1);
    check("to_err", timeout_err, 1);
    check("to_f_zero", f_out, 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("to_after_vld", out_valid, 0);
    check("to_sticky", timeout_err, 1);
    check("to_after_rdy", in_ready, 1);
`else
    for (int i = 0; i < 6; i++) begin
      tick();
      check("fe_vld", out_valid, 0);
      check("fe_rdy", in_ready, 0);
      check("fe_err", timeout_err, 0);
    end
`endif
    mode = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("final_rdy", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
